// File: rtl/fmul_ctrl_pkg.sv
// Shared types and constants for the shared single-precision multiplier
// controller and its datapath.
package fmul_ctrl_pkg;

    localparam int FP_W    = 32;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/floatingmultiplier.sv
// Combinational single-precision multiplier, truncating; denormals flush to
// zero, inf/NaN operands or exponent overflow raise invalid and give inf.
module floatingmultiplier
    import fmul_ctrl_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] product,
    output logic            invalid
);

    logic        sign;
    logic [47:0] mant;
    logic [9:0]  esum;
    logic [9:0]  eout;
    logic [22:0] frac;

    always_comb begin
        sign = a[31] ^ b[31];
        mant = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        esum = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'd0, mant[47]};
        eout = esum - 10'd127;
        frac = mant[47] ? mant[46:24] : mant[45:23];
        product = {sign, 31'd0};
        invalid = 1'b0;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            product = {sign, 8'hFF, 23'd0};
            invalid = 1'b1;
        end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
            product = {sign, 31'd0};
        end else if (esum > 10'd381) begin
            product = {sign, 8'hFF, 23'd0};
            invalid = 1'b1;
        end else if (esum >= 10'd128) begin
            // esum below 128 is underflow and keeps the signed-zero default
            product = {sign, eout[7:0], frac};
        end
    end

endmodule

// File: rtl/fmul_share_ctrl.sv
// Two-port arbiter sharing one combinational FP multiplier: grant in IDLE,
// capture the product in EXEC, hold it in RESP until the consumer takes it.
module fmul_share_ctrl
    import fmul_ctrl_pkg::*;
#(
    parameter int RR_EN     = 1,
    parameter int EXC_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [FP_W-1:0]      req0_a,
    input  logic [FP_W-1:0]      req0_b,
    input  logic [FP_W-1:0]      req1_a,
    input  logic [FP_W-1:0]      req1_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [FP_W-1:0]      rsp_product,
    output logic                 rsp_ovf,
    output logic                 busy,
    output logic [EXC_CNT_W-1:0] exc_count,
    input  logic                 exc_clr
);

    state_t          state;
    state_t          state_nx;
    logic            last;
    logic            hs;
    logic            hs_id;
    logic [FP_W-1:0] op_a;
    logic [FP_W-1:0] op_b;
    logic            op_id;
    logic [FP_W-1:0] mul_p;
    logic            mul_inv;

    // last holds the previously granted port; 1 after reset so port 0 wins
    always_comb begin
        req_ready = '0;
        if (state == IDLE) begin
            if (req_valid == 2'b11) begin
                req_ready = (RR_EN != 0 && !last) ? 2'b10 : 2'b01;
            end else begin
                req_ready = req_valid;
            end
        end
    end

    assign hs        = |req_ready;
    assign hs_id     = req_ready[1];
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (hs) state_nx = EXEC;
            EXEC: state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last  <= 1'b1;
            op_a  <= '0;
            op_b  <= '0;
            op_id <= 1'b0;
        end else if (hs) begin
            last  <= hs_id;
            op_a  <= hs_id ? req1_a : req0_a;
            op_b  <= hs_id ? req1_b : req0_b;
            op_id <= hs_id;
        end
    end

    floatingmultiplier u_mul (
        .a       (op_a),
        .b       (op_b),
        .product (mul_p),
        .invalid (mul_inv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_product <= '0;
            rsp_ovf     <= 1'b0;
            rsp_id      <= 1'b0;
        end else if (state == EXEC) begin
            rsp_product <= mul_p;
            rsp_ovf     <= mul_inv;
            rsp_id      <= op_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_count <= '0;
        end else if (exc_clr) begin
            exc_count <= '0;
        end else if (state == EXEC && mul_inv && !(&exc_count)) begin
            exc_count <= exc_count + EXC_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fmul_share_ctrl.sv
// Bench for fmul_share_ctrl: vector table, directed corner sequences and a
// randomized run against a transaction-level model.
module tb_fmul_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_ready;
    logic        exc_clr;

    logic [1:0]  req_ready, fp_req_ready;
    logic        rsp_valid, fp_rsp_valid;
    logic        rsp_id, fp_rsp_id;
    logic [31:0] rsp_product, fp_rsp_product;
    logic        rsp_ovf, fp_rsp_ovf;
    logic        busy, fp_busy;
    logic [7:0]  exc_count;
    logic [1:0]  fp_exc_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fmul_share_ctrl #(.RR_EN(1), .EXC_CNT_W(8)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_ovf(rsp_ovf), .busy(busy),
        .exc_count(exc_count), .exc_clr(exc_clr)
    );

    fmul_share_ctrl #(.RR_EN(0), .EXC_CNT_W(2)) u_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fp_req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_product(fp_rsp_product), .rsp_ovf(fp_rsp_ovf), .busy(fp_busy),
        .exc_count(fp_exc_count), .exc_clr(exc_clr)
    );

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic        ovf;
        int          hold;
    } vec_t;

    vec_t vecs[10];
    int   exp_cnt;
    int   exp_fp_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        exc_clr   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt    = 0;
        exp_fp_cnt = 0;
    endtask

    function automatic logic [32:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
        logic   s;
        int     ea, eb, e;
        longint m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {1'b1, s, 8'hFF, 23'h0};
        if (ea == 0 || eb == 0) return {1'b0, s, 31'h0};
        m = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        e = ea + eb - 127;
        if (m >= (longint'(1) << 47)) begin
            m = m >>> 24;
            e++;
        end else begin
            m = m >>> 23;
        end
        if (e > 254) return {1'b1, s, 8'hFF, 23'h0};
        if (e < 1) return {1'b0, s, 31'h0};
        return {1'b0, s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [31:0] m;
        m = $urandom;
        case ($urandom_range(0, 7))
            0: e = 8'h00;
            1: e = 8'hFF;
            2: e = 8'($urandom_range(190, 254));
            3: e = 8'($urandom_range(1, 60));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, m[22:0]};
    endfunction

    task automatic run_op(input vec_t v, input string nm);
        req_valid = v.port ? 2'b10 : 2'b01;
        if (v.port) begin
            req1_a = v.a;
            req1_b = v.b;
        end else begin
            req0_a = v.a;
            req0_b = v.b;
        end
        @(negedge clk);
        chk({nm, "_grant"}, 32'(req_ready), v.port ? 32'h2 : 32'h1);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk({nm, "_exec_valid"}, 32'(rsp_valid), 32'h0);
        chk({nm, "_exec_busy"}, 32'(busy), 32'h1);
        step();
        if (v.hold > 0) begin
            rsp_ready = 1'b0;
            req_valid = 2'b11;
        end
        @(negedge clk);
        chk({nm, "_valid"}, 32'(rsp_valid), 32'h1);
        chk({nm, "_product"}, rsp_product, v.p);
        chk({nm, "_ovf"}, 32'(rsp_ovf), 32'(v.ovf));
        chk({nm, "_id"}, 32'(rsp_id), 32'(v.port));
        for (int i = 0; i < v.hold; i++) begin
            step();
            if (i == v.hold - 1) begin
                rsp_ready = 1'b1;
                req_valid = 2'b00;
            end
            @(negedge clk);
            chk({nm, "_hold_valid"}, 32'(rsp_valid), 32'h1);
            chk({nm, "_hold_product"}, rsp_product, v.p);
            chk({nm, "_hold_ready"}, 32'(req_ready), 32'h0);
            chk({nm, "_hold_busy"}, 32'(busy), 32'h1);
        end
        step();
        if (v.ovf) begin
            exp_cnt++;
            if (exp_fp_cnt < 3) exp_fp_cnt++;
        end
        @(negedge clk);
        chk({nm, "_done_valid"}, 32'(rsp_valid), 32'h0);
        chk({nm, "_done_busy"}, 32'(busy), 32'h0);
        chk({nm, "_idle_product"}, rsp_product, v.p);
        chk({nm, "_exc_count"}, 32'(exc_count), 32'(exp_cnt));
        chk({nm, "_fp_exc_count"}, 32'(fp_exc_count), 32'(exp_fp_cnt));
        step();
    endtask

    initial begin
        int          ngrant;
        int          m_phase;
        logic        m_last;
        logic        m_id;
        logic [31:0] m_a, m_b, m_prod;
        logic        m_ovf;
        int          m_cnt;
        logic [1:0]  eg;
        logic [32:0] r;

        vecs[0] = '{1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 0};
        vecs[1] = '{1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 5};
        vecs[2] = '{1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 0};
        vecs[3] = '{1'b1, 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1};
        vecs[4] = '{1'b0, 32'h00000000, 32'h40400000, 32'h00000000, 1'b0, 0};
        vecs[5] = '{1'b1, 32'h40800000, 32'h3E800000, 32'h3F800000, 1'b0, 2};
        vecs[6] = '{1'b0, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 0};
        vecs[7] = '{1'b1, 32'hFF000000, 32'h7F000000, 32'hFF800000, 1'b1, 0};
        vecs[8] = '{1'b0, 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b1, 3};
        vecs[9] = '{1'b1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 0};

        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_product", rsp_product, 32'h0);
        chk("rst_ovf", 32'(rsp_ovf), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        chk("rst_exc", 32'(exc_count), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // clear coinciding with an overflow capture must win
        req_valid = 2'b01;
        req0_a = 32'h7F000000;
        req0_b = 32'h7F000000;
        step();
        req_valid = 2'b00;
        exc_clr = 1'b1;
        step();
        exc_clr = 1'b0;
        @(negedge clk);
        chk("clr_win_count", 32'(exc_count), 32'h0);
        chk("clr_win_fp_count", 32'(fp_exc_count), 32'h0);
        chk("clr_win_ovf", 32'(rsp_ovf), 32'h1);
        step();
        step();

        // continuous contention
        do_reset();
        req_valid = 2'b11;
        req0_a = 32'h40000000; req0_b = 32'h40000000;
        req1_a = 32'h40400000; req1_b = 32'h40400000;
        ngrant = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                chk($sformatf("rr_grant%0d", ngrant), 32'(req_ready),
                    (ngrant % 2 == 0) ? 32'h1 : 32'h2);
                chk($sformatf("fp_grant%0d", ngrant), 32'(fp_req_ready), 32'h1);
                ngrant++;
            end
            step();
        end
        chk("rr_grant_total", 32'(ngrant), 32'd4);
        req_valid = 2'b00;
        repeat (3) step();

        // reset pulse while in EXEC discards the operation
        req_valid = 2'b10;
        req1_a = 32'h40000000; req1_b = 32'h40400000;
        step();
        req_valid = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_product", rsp_product, 32'h0);
        chk("midrst_exc", 32'(exc_count), 32'h0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("postrst_valid", 32'(rsp_valid), 32'h0);
            chk("postrst_id", 32'(rsp_id), 32'h0);
            chk("postrst_product", rsp_product, 32'h0);
            step();
        end
        exp_cnt = 0;
        exp_fp_cnt = 0;
        run_op(vecs[1], "postrst_op");

        // randomized run against a transaction-level model
        do_reset();
        m_phase = 0;
        m_last = 1'b1;
        m_id = 1'b0;
        m_a = '0; m_b = '0; m_prod = '0; m_ovf = 1'b0;
        m_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = 2'($urandom_range(0, 3));
            req0_a = rand_fp(); req0_b = rand_fp();
            req1_a = rand_fp(); req1_b = rand_fp();
            rsp_ready = ($urandom_range(0, 3) != 0);
            exc_clr = ($urandom_range(0, 19) == 0);
            eg = 2'b00;
            if (m_phase == 0) begin
                if (req_valid == 2'b11) eg = m_last ? 2'b01 : 2'b10;
                else eg = req_valid;
            end
            @(negedge clk);
            chk("rnd_ready", 32'(req_ready), 32'(eg));
            chk("rnd_busy", 32'(busy), 32'(m_phase != 0));
            chk("rnd_valid", 32'(rsp_valid), 32'(m_phase == 2));
            chk("rnd_exc", 32'(exc_count), 32'(m_cnt));
            if (m_phase == 2) begin
                chk("rnd_product", rsp_product, m_prod);
                chk("rnd_ovf", 32'(rsp_ovf), 32'(m_ovf));
                chk("rnd_id", 32'(rsp_id), 32'(m_id));
            end
            step();
            r = ref_mul(m_a, m_b);
            if (exc_clr) m_cnt = 0;
            else if (m_phase == 1 && r[32] && m_cnt < 255) m_cnt++;
            case (m_phase)
                0: if (eg != 2'b00) begin
                    m_id = eg[1];
                    m_a = m_id ? req1_a : req0_a;
                    m_b = m_id ? req1_b : req0_b;
                    m_last = m_id;
                    m_phase = 1;
                end
                1: begin
                    m_ovf = r[32];
                    m_prod = r[31:0];
                    m_phase = 2;
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
